screen_framebuffer: RTL and testbench
=====================================

Name: screen_framebuffer

Overview:
Double-buffered 32x32 RGB (3 bpp) frame store between the rv32i bus and the 32x32 HUB75 scan driver.
- CPU side: draws into the back buffer through a small register interface.
- Scan side: reads the front buffer as top/bottom pixel pairs for rows r and r+16.
- Buffer swap is requested by the CPU and committed only on the scanner's frame boundary, so no tearing.

Parameters:
- FB_W, 32, pixels per row (x width 5 bits)
- FB_H, 32, rows (y width 5 bits; scan half = FB_H/2)
- PIX_BITS, 3, bits per pixel {R,G,B}, R in MSB

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cs  in  1  peripheral select
- rd  in  1  bus read strobe (with cs)
- wr  in  1  bus write strobe (with cs)
- addr  in  5  byte register offset
- d_in  in  32  bus write data
- d_out  out  32  bus read data, registered
- frame_done  in  1  one-cycle pulse from scan driver after last row of a frame
- scan_row  in  4  scan row 0..15
- scan_col  in  5  column 0..31
- rgb_top  out  3  front-buffer pixel (scan_col, scan_row)
- rgb_bot  out  3  front-buffer pixel (scan_col, scan_row+16)
- irq  out  1  only when SCREEN_FB_IRQ_EN defined

Behaviour:
- Reset (rst=0, async): front=0, swap_pending=0, fill_busy=0, pix_addr=0, fill_cnt=0, d_out=0, rgb_top=rgb_bot=0, irq=0. Memory contents are not reset.
- Register map (cs&wr writes; cs&rd reads, d_out valid next cycle, holds otherwise):
  - 0x00 PIX_ADDR RW: [9:5]=y, [4:0]=x.
  - 0x04 PIX_DATA: write stores d_in[2:0] to back[pix_addr], then pix_addr+1 mod 1024 (1023 wraps to 0). Read returns back[pix_addr]; no increment.
  - 0x08 CTRL: write bit0=1 sets swap_pending; write bit1=1 clears irq. Read: bit0 swap_pending, bit1 front, bit2 fill_busy, bit3 irq.
  - 0x0C FILL: write latches color d_in[2:0], sets fill_busy, fill_cnt=0. Read returns {29'b0, fill color}.
  - Other offsets: reads return 0, writes are ignored.
- Fill engine:
  - While busy, writes color to back[fill_cnt] each cycle and increments.
  - After fill_cnt=1023 is written: fill_busy=0 (1024 cycles total).
  - PIX_DATA writes during a fill are ignored; pix_addr is unchanged.
  - A FILL write during a fill restarts at 0 with the new color.
- Swap:
  - Commits when frame_done=1 and swap_pending=1 and fill_busy=0: front toggles and swap_pending clears in the same edge.
  - frame_done with fill_busy=1 defers the swap to the next qualifying frame_done.
  - Swap request while already pending: no effect.
  - CTRL swap write in the same cycle as a committing frame_done: the commit happens and pending stays 0. The new request is absorbed, not re-armed.
- Scan read: rgb_top/rgb_bot registered, 1-cycle latency from scan_row/scan_col. Always reads the front buffer current at the sampling edge.
- Back-buffer reads and writes never touch the front buffer.
- Storage: 2x1024x3. The scan port needs two reads per cycle, so top and bottom halves are separate banks (inferable BRAM).

Optional Feature:
SCREEN_FB_IRQ_EN
- Defined: irq port present; irq sets on the cycle a swap commits and stays high until a CTRL write with bit1=1. If set and clear coincide, set wins.
- Undefined: no irq port; CTRL bit3 reads 0; CTRL bit1 write is ignored.

Test Plan:
- Reset mid-fill: assert rst during fill_cnt≈500 -> fill_busy=0, d_out=0, front=0 immediately; no further writes to memory.
- Pixel write and readback: PIX_ADDR=0x3FF, PIX_DATA write 3'b101 -> pix_addr wraps to 0; PIX_ADDR=0x3FF then PIX_DATA read -> d_out[2:0]=101 one cycle after rd.
- Swap timing: back pixel (x=3,y=20)=3'b010, CTRL=1 -> scan shows old data until frame_done. Next cycle front=1; scan_row=4, scan_col=3 -> rgb_bot=010 one cycle later.
- Fill vs swap: FILL=3'b111, CTRL=1, frame_done at cycle 100 -> no swap, swap_pending=1. After 1024 fill cycles, next frame_done swaps; all 1024 scan reads return 111.
- Fill blocks pixel writes: PIX_DATA write during fill -> pix_addr unchanged; pixel ends as fill color.
- IRQ (macro on): swap commits -> irq=1. CTRL write 0x2 -> irq=0 next cycle. Simultaneous commit and clear -> irq=1.

Source files
------------

// File: rtl/screen_framebuffer.sv
// screen_framebuffer: double-buffered 32x32 RGB frame store (CPU back-buffer port, HUB75 scan port).
// Optional swap interrupt output enabled by defining SCREEN_FB_IRQ_EN.
`default_nettype none

module screen_framebuffer #(
  parameter int FB_W     = 32,
  parameter int FB_H     = 32,
  parameter int PIX_BITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        rd,
  input  logic                        wr,
  input  logic [4:0]                  addr,
  input  logic [31:0]                 d_in,
  output logic [31:0]                 d_out,
  input  logic                        frame_done,
  input  logic [$clog2(FB_H)-2:0]     scan_row,
  input  logic [$clog2(FB_W)-1:0]     scan_col,
  output logic [PIX_BITS-1:0]         rgb_top,
  output logic [PIX_BITS-1:0]         rgb_bot
`ifdef SCREEN_FB_IRQ_EN
  ,
  output logic                        irq
`endif
);

  localparam int XW    = $clog2(FB_W);
  localparam int YW    = $clog2(FB_H);
  localparam int AW    = XW + YW;
  localparam int DEPTH = 2 ** AW;

  localparam logic [4:0]    REG_PIX_ADDR = 5'h00;
  localparam logic [4:0]    REG_PIX_DATA = 5'h04;
  localparam logic [4:0]    REG_CTRL     = 5'h08;
  localparam logic [4:0]    REG_FILL     = 5'h0C;
  localparam logic [AW-1:0] ADDR_ONE     = AW'(1);

  // Each bank holds one screen half for both buffers: index = {buffer, row-in-half, x}.
  logic [PIX_BITS-1:0] bank_top [DEPTH];
  logic [PIX_BITS-1:0] bank_bot [DEPTH];

  logic                front;
  logic                swap_pending;
  logic                fill_busy;
  logic [AW-1:0]       pix_addr;
  logic [AW-1:0]       fill_cnt;
  logic [PIX_BITS-1:0] fill_color;
  logic                irq_q;

  logic                wr_pix_addr;
  logic                wr_pix_data;
  logic                wr_ctrl;
  logic                wr_fill;
  logic                commit;

  logic                mem_we;
  logic [AW-1:0]       mem_wa;
  logic [PIX_BITS-1:0] mem_wd;
  logic [AW-1:0]       mem_bank_addr;
  logic [AW-1:0]       cpu_bank_addr;
  logic [PIX_BITS-1:0] back_rd;
  logic [31:0]         rd_data;

  logic                unused_bits;
  assign unused_bits = ^d_in[31:AW];

  assign wr_pix_addr = cs && wr && (addr == REG_PIX_ADDR);
  assign wr_pix_data = cs && wr && (addr == REG_PIX_DATA) && !fill_busy;
  assign wr_ctrl     = cs && wr && (addr == REG_CTRL);
  assign wr_fill     = cs && wr && (addr == REG_FILL);
  assign commit      = frame_done && swap_pending && !fill_busy;

  // Back-buffer write port, shared by the fill engine (priority) and PIX_DATA writes.
  always_comb begin
    mem_we        = rst && (fill_busy || wr_pix_data);
    mem_wa        = fill_busy ? fill_cnt : pix_addr;
    mem_wd        = fill_busy ? fill_color : d_in[PIX_BITS-1:0];
    mem_bank_addr = {~front, mem_wa[AW-2:0]};
  end

  always_ff @(posedge clk) begin
    if (mem_we && !mem_wa[AW-1]) begin
      bank_top[mem_bank_addr] <= mem_wd;
    end
    if (mem_we && mem_wa[AW-1]) begin
      bank_bot[mem_bank_addr] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_top <= '0;
      rgb_bot <= '0;
    end else begin
      rgb_top <= bank_top[{front, scan_row, scan_col}];
      rgb_bot <= bank_bot[{front, scan_row, scan_col}];
    end
  end

  always_comb begin
    cpu_bank_addr = {~front, pix_addr[AW-2:0]};
    back_rd       = pix_addr[AW-1] ? bank_bot[cpu_bank_addr] : bank_top[cpu_bank_addr];
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_PIX_ADDR: rd_data = {{(32-AW){1'b0}}, pix_addr};
      REG_PIX_DATA: rd_data = {{(32-PIX_BITS){1'b0}}, back_rd};
      REG_CTRL:     rd_data = {28'b0, irq_q, fill_busy, front, swap_pending};
      REG_FILL:     rd_data = {{(32-PIX_BITS){1'b0}}, fill_color};
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
    end else if (cs && rd) begin
      d_out <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_addr <= '0;
    end else if (wr_pix_addr) begin
      pix_addr <= d_in[AW-1:0];
    end else if (wr_pix_data) begin
      pix_addr <= pix_addr + ADDR_ONE;
    end
  end

  // Fill engine: a FILL write restarts from 0 even when a fill is already running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_busy  <= 1'b0;
      fill_cnt   <= '0;
      fill_color <= '0;
    end else if (wr_fill) begin
      fill_busy  <= 1'b1;
      fill_cnt   <= '0;
      fill_color <= d_in[PIX_BITS-1:0];
    end else if (fill_busy) begin
      fill_cnt <= fill_cnt + ADDR_ONE;
      if (fill_cnt == '1) begin
        fill_busy <= 1'b0;
      end
    end
  end

  // A request arriving on the committing edge is absorbed rather than re-armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
    end else if (commit) begin
      front        <= ~front;
      swap_pending <= 1'b0;
    end else if (wr_ctrl && d_in[0]) begin
      swap_pending <= 1'b1;
    end
  end

`ifdef SCREEN_FB_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else if (commit) begin
      irq_q <= 1'b1;
    end else if (wr_ctrl && d_in[1]) begin
      irq_q <= 1'b0;
    end
  end
  assign irq = irq_q;
`else
  assign irq_q = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_screen_framebuffer.sv
// tb_screen_framebuffer: register table, directed swap/fill/reset sequences and random traffic
// checked against an array-based model of both frame buffers.
`default_nettype none

module tb_screen_framebuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic        frame_done = 1'b0;
  logic [3:0]  scan_row = '0;
  logic [4:0]  scan_col = '0;
  logic [2:0]  rgb_top, rgb_bot;
`ifdef SCREEN_FB_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  screen_framebuffer dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .d_in(d_in),
    .d_out(d_out), .frame_done(frame_done), .scan_row(scan_row), .scan_col(scan_col),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot)
`ifdef SCREEN_FB_IRQ_EN
    , .irq(irq)
`endif
  );

  // Model: two frame buffers indexed by y*32+x, plus validity of each stored pixel.
  logic [2:0]  fb [2][1024];
  bit          kn [2][1024];
  bit          m_front, m_pend, m_busy, m_irq;
  int          m_cnt, m_pix;
  logic [2:0]  m_color;
  logic [31:0] m_dout;
  logic [2:0]  m_top, m_bot;
  bit          dout_kn, top_kn, bot_kn;
  int          n_vec = 0, n_err = 0;

  typedef struct {
    bit          cs, rd, wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int back, ti, bi;
    bit wpa, wpd, wct, wfi, commit;
    back = m_front ? 0 : 1;
    wpa = cs && wr && addr == 5'h00;
    wpd = cs && wr && addr == 5'h04;
    wct = cs && wr && addr == 5'h08;
    wfi = cs && wr && addr == 5'h0C;
    if (cs && rd) begin
      dout_kn = 1;
      case (addr)
        5'h00: m_dout = 32'(m_pix);
        5'h04: begin m_dout = {29'b0, fb[back][m_pix]}; dout_kn = kn[back][m_pix]; end
        5'h08: m_dout = {28'b0, m_irq, m_busy, m_front, m_pend};
        5'h0C: m_dout = {29'b0, m_color};
        default: m_dout = 32'h0;
      endcase
    end
    ti = int'(scan_row) * 32 + int'(scan_col);
    bi = ti + 16 * 32;
    m_top = fb[m_front][ti]; top_kn = kn[m_front][ti];
    m_bot = fb[m_front][bi]; bot_kn = kn[m_front][bi];
    commit = frame_done && m_pend && !m_busy;
    if (m_busy) begin
      fb[back][m_cnt] = m_color; kn[back][m_cnt] = 1;
    end else if (wpd) begin
      fb[back][m_pix] = d_in[2:0]; kn[back][m_pix] = 1;
    end
    if (wpa) m_pix = int'(d_in[9:0]);
    else if (wpd && !m_busy) m_pix = (m_pix + 1) % 1024;
    if (wfi) begin
      m_busy = 1; m_cnt = 0; m_color = d_in[2:0];
    end else if (m_busy) begin
      if (m_cnt == 1023) m_busy = 0;
      else m_cnt++;
    end
    if (commit) begin
      m_front = !m_front; m_pend = 0;
    end else if (wct && d_in[0]) m_pend = 1;
`ifdef SCREEN_FB_IRQ_EN
    if (commit) m_irq = 1;
    else if (wct && d_in[1]) m_irq = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_front = 0; m_pend = 0; m_busy = 0; m_irq = 0; m_cnt = 0; m_pix = 0; m_color = 0;
      m_dout = 0; m_top = 0; m_bot = 0; dout_kn = 1; top_kn = 1; bot_kn = 1;
    end else begin
      model_step();
    end
    #1;
    if (dout_kn) chk("d_out", d_out, m_dout);
    if (top_kn)  chk("rgb_top", 32'(rgb_top), 32'(m_top));
    if (bot_kn)  chk("rgb_bot", 32'(rgb_bot), 32'(m_bot));
`ifdef SCREEN_FB_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic idle_inputs();
    cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0; frame_done = 0;
  endtask

  task automatic bus(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d);
    cs = 1; rd = r; wr = w; addr = a; d_in = d;
    tick();
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_frame();
    frame_done = 1;
    tick();
    frame_done = 0;
  endtask

  task automatic wait_fill();
    int guard = 0;
    while (m_busy && guard < 1100) begin
      scan_row = 4'($urandom); scan_col = 5'($urandom);
      tick();
      guard++;
    end
    bus(1, 0, 5'h08, 0);
    chk("fill_idle", d_out & 32'h4, 32'h0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] c, old;
    tbl[0]  = '{1, 0, 1, 5'h00, 32'h0000_03FF, 32'h0};
    tbl[1]  = '{1, 1, 0, 5'h00, 32'h0,         32'h3FF};
    tbl[2]  = '{1, 0, 1, 5'h00, 32'h0001_2345, 32'h3FF};
    tbl[3]  = '{1, 1, 0, 5'h00, 32'h0,         32'h345};
    tbl[4]  = '{1, 1, 0, 5'h10, 32'h0,         32'h0};
    tbl[5]  = '{1, 0, 1, 5'h10, 32'hFFFF,      32'h0};
    tbl[6]  = '{1, 1, 0, 5'h08, 32'h0,         32'h0};
    tbl[7]  = '{1, 0, 1, 5'h08, 32'h1,         32'h0};
    tbl[8]  = '{1, 1, 0, 5'h08, 32'h0,         32'h1};
    tbl[9]  = '{1, 0, 1, 5'h08, 32'h1,         32'h1};
    tbl[10] = '{1, 1, 0, 5'h08, 32'h0,         32'h1};
    tbl[11] = '{0, 1, 0, 5'h00, 32'h0,         32'h1};
    tbl[12] = '{1, 0, 1, 5'h0C, 32'hFFFF_FFFE, 32'h1};
    tbl[13] = '{1, 1, 0, 5'h0C, 32'h0,         32'h6};
    tbl[14] = '{1, 1, 0, 5'h08, 32'h0,         32'h5};
    tbl[15] = '{1, 1, 0, 5'h1C, 32'h0,         32'h0};

    // Reset state
    idle(3);
    rst = 1;
    chk("reset_d_out", d_out, 32'h0);
    chk("reset_rgb_top", 32'(rgb_top), 32'h0);

    // Register table
    for (int i = 0; i < 16; i++) begin
      cs = tbl[i].cs; rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].a; d_in = tbl[i].d;
      tick();
      idle_inputs();
      chk($sformatf("tbl%0d", i), d_out, tbl[i].exp);
    end

    // Make both buffers fully known: fill back (6), swap, fill the other (3)
    wait_fill();
    pulse_frame();
    bus(0, 1, 5'h0C, 32'h3);
    wait_fill();

    // Pixel write wrap and readback
    bus(0, 1, 5'h00, 32'h3FF);
    bus(0, 1, 5'h04, 32'h5);
    bus(1, 0, 5'h00, 0);
    chk("pix_wrap", d_out, 32'h0);
    bus(0, 1, 5'h00, 32'h3FF);
    bus(1, 0, 5'h04, 0);
    chk("pix_readback", d_out, 32'h5);

    // Swap timing: pixel (3,20) appears on rgb_bot only after frame_done
    bus(0, 1, 5'h00, 32'(20 * 32 + 3));
    bus(0, 1, 5'h04, 32'h2);
    bus(0, 1, 5'h08, 32'h1);
    scan_row = 4; scan_col = 3;
    idle(3);
    pulse_frame();
    tick();
    chk("swap_rgb_bot", 32'(rgb_bot), 32'h2);

    // Fill defers swap; afterwards whole screen shows fill color
    bus(0, 1, 5'h0C, 32'h7);
    bus(0, 1, 5'h08, 32'h1);
    idle(95);
    pulse_frame();
    bus(1, 0, 5'h08, 0);
    chk("swap_deferred", d_out & 32'h5, 32'h5);
    wait_fill();
    pulse_frame();
    for (int r = 0; r < 16; r++) begin
      for (int col = 0; col < 32; col++) begin
        scan_row = 4'(r); scan_col = 5'(col);
        tick();
        chk("fill_scan_top", 32'(rgb_top), 32'h7);
        chk("fill_scan_bot", 32'(rgb_bot), 32'h7);
      end
    end

    // Fill blocks PIX_DATA writes
    bus(0, 1, 5'h0C, 32'h4);
    bus(0, 1, 5'h00, 32'd77);
    bus(0, 1, 5'h04, 32'h1);
    bus(1, 0, 5'h00, 0);
    chk("fill_blocks_addr", d_out, 32'd77);
    wait_fill();
    bus(1, 0, 5'h04, 0);
    chk("fill_wins_pixel", d_out, 32'h4);

    // Swap request coinciding with commit is absorbed
    bus(0, 1, 5'h08, 32'h1);
    cs = 1; wr = 1; addr = 5'h08; d_in = 32'h1; frame_done = 1;
    tick();
    idle_inputs();
`ifdef SCREEN_FB_IRQ_EN
    chk("irq_set", 32'(irq), 32'h1);
`endif
    bus(1, 0, 5'h08, 0);
    chk("swap_absorbed", d_out & 32'h1, 32'h0);
    bus(0, 1, 5'h08, 32'h2);
`ifdef SCREEN_FB_IRQ_EN
    chk("irq_clear", 32'(irq), 32'h0);
    bus(0, 1, 5'h08, 32'h1);
    cs = 1; wr = 1; addr = 5'h08; d_in = 32'h2; frame_done = 1;
    tick();
    idle_inputs();
    chk("irq_set_wins", 32'(irq), 32'h1);
    bus(0, 1, 5'h08, 32'h2);
`endif

    // Reset mid-fill: fill target is buffer 1, later entries must keep old data
    if (m_front) begin
      bus(0, 1, 5'h08, 32'h1);
      pulse_frame();
    end
    old = fb[1][1000];
    c = old + 3'd1;
    bus(0, 1, 5'h0C, 32'(c));
    idle(500);
    rst = 0;
    #1;
    chk("rst_async_d_out", d_out, 32'h0);
    chk("rst_async_rgb_top", 32'(rgb_top), 32'h0);
    chk("rst_async_rgb_bot", 32'(rgb_bot), 32'h0);
    idle(2);
    rst = 1;
    idle(3);
    bus(1, 0, 5'h08, 0);
    chk("rst_ctrl", d_out, 32'h0);
    for (int i = 480; i < 540; i += 3) begin
      bus(0, 1, 5'h00, 32'(i));
      bus(1, 0, 5'h04, 0);
    end
    bus(0, 1, 5'h00, 32'd1000);
    bus(1, 0, 5'h04, 0);
    chk("no_write_after_rst", d_out, 32'(old));

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(99));
      idle_inputs();
      scan_row = 4'($urandom); scan_col = 5'($urandom);
      frame_done = ($urandom_range(15) == 0);
      addr = 5'(4 * $urandom_range(4));
      d_in = $urandom;
      if (r < 35) begin
        cs = 1; wr = 1;
        if (addr == 5'h0C && $urandom_range(49) != 0) addr = 5'h04;
      end else if (r < 70) begin
        cs = 1; rd = 1;
      end else if (r < 75) begin
        rd = 1; wr = 1;
      end
      tick();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
